// File: rtl/ex_mdu.sv
// ex_mdu: execute stage with combinational logic/shift/add-sub and a 32-step iterative divider.
module ex_mdu #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUSEL_W-1:0]   alusel_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  annul_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  whilo_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  stallreq_o
);
    localparam int SW = $clog2(DATA_W);
    localparam logic [SW-1:0] LAST = SW'(DATA_W - 1);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(1), SEL_SHIFT = ALUSEL_W'(2),
                                    SEL_ARITH = ALUSEL_W'(4);
    localparam logic [ALUOP_W-1:0] OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26, OP_NOR = 8'h27,
                                   OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03,
                                   OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;
    state_t state, state_n;

    logic [SW-1:0]     cnt;
    logic [DATA_W-1:0] dvd, dvs, rem, a1, a2, sra_r, res;
    logic [DATA_W:0]   trial, diff;
    logic              neg_q, neg_r, is_sdiv, start;
    logic [SW-1:0]     sh;

    assign sh      = reg1_i[SW-1:0];
    assign sra_r   = $unsigned($signed(reg2_i) >>> sh);
    assign is_sdiv = aluop_i == OP_DIV;
    assign start   = (is_sdiv || aluop_i == OP_DIVU) && !annul_i;
    assign a1      = is_sdiv && reg1_i[DATA_W-1] ? -reg1_i : reg1_i;
    assign a2      = is_sdiv && reg2_i[DATA_W-1] ? -reg2_i : reg2_i;
    // Restoring step: quotient bits shift into dvd as dividend bits shift out
    assign trial   = {rem, dvd[DATA_W-1]};
    assign diff    = trial - {1'b0, dvs};

    always_comb begin
        res = '0;
        if (alusel_i == SEL_LOGIC)
            res = aluop_i == OP_OR  ? reg1_i | reg2_i :
                  aluop_i == OP_AND ? reg1_i & reg2_i :
                  aluop_i == OP_XOR ? reg1_i ^ reg2_i :
                  aluop_i == OP_NOR ? ~(reg1_i | reg2_i) : '0;
        else if (alusel_i == SEL_SHIFT)
            res = aluop_i == OP_SLL ? reg2_i << sh :
                  aluop_i == OP_SRL ? reg2_i >> sh :
                  aluop_i == OP_SRA ? sra_r : '0;
        else if (alusel_i == SEL_ARITH)
            res = aluop_i == OP_ADDU ? reg1_i + reg2_i :
                  aluop_i == OP_SUBU ? reg1_i - reg2_i : '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? (reg2_i == '0 ? S_BYZERO : S_ON) : S_IDLE;
            S_BYZERO: state_n = S_END;
            S_ON:     state_n = cnt == LAST ? S_END : S_ON;
            default:  state_n = S_IDLE;
        endcase
        if (annul_i && state != S_IDLE) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                dvd   <= a1;
                dvs   <= a2;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= is_sdiv && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                neg_r <= is_sdiv && reg1_i[DATA_W-1];
            end else if (state == S_BYZERO) begin
                dvd <= '0;
                rem <= '0;
            end else if (state == S_ON) begin
                dvd <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
                rem <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign wd_o       = rst ? '0 : wd_i;
    assign wreg_o     = !rst && wreg_i;
    assign wdata_o    = rst ? '0 : res;
    assign whilo_o    = state == S_END && !annul_i;
    assign lo_o       = whilo_o ? (neg_q ? -dvd : dvd) : '0;
    assign hi_o       = whilo_o ? (neg_r ? -rem : rem) : '0;
    assign stallreq_o = !rst && (state == S_IDLE ? start : (state != S_END && !annul_i));
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed checks of ex_mdu ALU results, divider latency, annul and async reset.
module tb_ex_mdu;
    logic        clk = 0, rst = 1, wreg_i = 0, annul_i = 0;
    logic [2:0]  alusel_i = 0;
    logic [7:0]  aluop_i = 0;
    logic [31:0] reg1_i = 0, reg2_i = 0;
    logic [4:0]  wd_i = 0;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    int errors = 0, checks = 0;

    ex_mdu dut (.clk(clk), .rst(rst), .alusel_i(alusel_i), .aluop_i(aluop_i), .reg1_i(reg1_i),
                .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .annul_i(annul_i), .wd_o(wd_o),
                .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
                .stallreq_o(stallreq_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b;
        #1;
        chk(tag, wdata_o, exp);
    endtask

    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_n, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input bit scramble);
        int n = 0;
        alusel_i = 3'b000; aluop_i = op; reg1_i = a; reg2_i = b;
        #1;
        chk({tag, "_wdata"}, wdata_o, 0);
        while (stallreq_o && n < 100) begin
            tick();
            n++;
            if (scramble) begin reg1_i = 32'h1234_5678; reg2_i = 32'h0000_0003; end
        end
        chk({tag, "_stall_cycles"}, n, exp_n);
        chk({tag, "_whilo"}, whilo_o, 1);
        chk({tag, "_lo"}, lo_o, exp_lo);
        chk({tag, "_hi"}, hi_o, exp_hi);
        aluop_i = 8'h00;
        tick();
        chk({tag, "_whilo_after"}, whilo_o, 0);
        chk({tag, "_hilo_after"}, {hi_o[15:0], lo_o[15:0]}, 0);
    endtask

    initial begin
        int pulses;
        alusel_i = 3'b001; aluop_i = 8'h25; reg1_i = 32'h0F0F_0000; reg2_i = 32'hFF;
        wd_i = 5; wreg_i = 1;
        #12;
        chk("rst_wd", wd_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_stall_whilo", {stallreq_o, whilo_o}, 0);
        chk("rst_hilo", hi_o | lo_o, 0);
        @(negedge clk);
        rst = 0;
        tick();
        #1;
        chk("or_wdata", wdata_o, 32'h0F0F_00FF);
        chk("or_wd", wd_o, 5);
        chk("or_wreg", wreg_o, 1);
        chk("or_stall", stallreq_o, 0);
        alu("and", 3'b001, 8'h24, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000);
        alu("xor", 3'b001, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu("nor", 3'b001, 8'h27, 32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0);
        alu("sll", 3'b010, 8'h7C, 32'd8, 32'h0000_00AB, 32'h0000_AB00);
        alu("srl", 3'b010, 8'h02, 32'd36, 32'h8000_0000, 32'h0800_0000);
        alu("sra", 3'b010, 8'h03, 32'd4, 32'h8000_0000, 32'hF800_0000);
        alu("sra_pos", 3'b010, 8'h03, 32'd4, 32'h7000_0000, 32'h0700_0000);
        alu("addu_wrap", 3'b100, 8'h21, 32'hFFFF_FFFF, 32'd2, 32'd1);
        alu("subu", 3'b100, 8'h23, 32'd0, 32'd1, 32'hFFFF_FFFF);
        alu("nop_sel", 3'b000, 8'h25, 32'hFF, 32'hFF, 0);
        alu("bad_op", 3'b001, 8'h7C, 32'hFF, 32'hFF, 0);
        alu("bad_sel", 3'b011, 8'h25, 32'hFF, 32'hFF, 0);
        aluop_i = 8'h00;
        tick();
        run_div("div_neg7_2", 8'h1A, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div("divu_big", 8'h1B, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'hF, 1);
        run_div("div_m1_16", 8'h1A, 32'hFFFF_FFFF, 32'h10, 33, 0, 32'hFFFF_FFFF, 0);
        run_div("div_100_m7", 8'h1A, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 0);
        run_div("div_zero", 8'h1A, 32'd77, 32'd0, 2, 0, 0, 0);
        alusel_i = 3'b000; aluop_i = 8'h1B; reg1_i = 32'd1000; reg2_i = 32'd7;
        for (int i = 0; i < 10; i++) tick();
        chk("annul_pre_stall", stallreq_o, 1);
        annul_i = 1; aluop_i = 8'h00;
        #1;
        chk("annul_stall", stallreq_o, 0);
        chk("annul_whilo", whilo_o, 0);
        tick();
        annul_i = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (whilo_o || stallreq_o) pulses++;
            tick();
        end
        chk("annul_no_result", pulses, 0);
        aluop_i = 8'h1B; wd_i = 7; wreg_i = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("rstmid_pre_stall", stallreq_o, 1);
        #2 rst = 1;
        #1;
        chk("rstmid_stall", stallreq_o, 0);
        chk("rstmid_outs", {27'd0, wd_o} | {31'd0, wreg_o} | wdata_o | hi_o | lo_o, 0);
        chk("rstmid_whilo", whilo_o, 0);
        aluop_i = 8'h00;
        @(negedge clk);
        rst = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (whilo_o || stallreq_o) pulses++;
        end
        chk("rstmid_discarded", pulses, 0);
        alu("addu_after_rst", 3'b100, 8'h21, 32'd3, 32'd4, 32'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Execute stage fed directly by the ID/EX pipeline register. It consumes alusel/aluop/operands/destination and produces the write-back triple for EX/MEM. Logic, shift and add/sub results are combinational. DIV/DIVU run on an iterative 32-step radix-2 divider FSM that stalls the pipeline via stallreq_o and delivers quotient/remainder on a HI/LO write port.

Parameters:
DATA_W, 32, operand/result width (divider iteration count equals DATA_W)
REG_ADDR_W, 5, GPR address width
ALUOP_W, 8, aluop width
ALUSEL_W, 3, alusel width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
alusel_i  input  ALUSEL_W  result class: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH
aluop_i  input  ALUOP_W  operation code (encodings below)
reg1_i  input  DATA_W  operand 1 (shift amount for shifts, dividend for divides)
reg2_i  input  DATA_W  operand 2 (shifted value, divisor)
wd_i  input  REG_ADDR_W  destination GPR
wreg_i  input  1  GPR write enable
annul_i  input  1  abort any in-flight divide (flush)
wd_o  output  REG_ADDR_W  destination GPR to EX/MEM
wreg_o  output  1  GPR write enable to EX/MEM
wdata_o  output  DATA_W  GPR write data
whilo_o  output  1  HI/LO write enable, one cycle
hi_o  output  DATA_W  remainder
lo_o  output  DATA_W  quotient
stallreq_o  output  1  hold upstream stages

Behaviour:
- Reset: clk and rst as named above; rst is asynchronous, active-high. While rst=1, every output is 0 and the FSM is forced to IDLE, counter 0, datapath registers 0. Reset mid-divide discards the operation.
- aluop encodings: OR 8'h25, AND 8'h24, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, ADDU 8'h21, SUBU 8'h23, DIV 8'h1A, DIVU 8'h1B.
- Pass-through: wd_o=wd_i and wreg_o=wreg_i, combinational.
- LOGIC: bitwise ops on reg1_i and reg2_i.
- SHIFT: uses reg2_i shifted by reg1_i[4:0]. SRA sign-fills.
- ARITH: ADDU/SUBU wrap modulo 2^32, with no overflow detection.
- wdata_o is 0 for NOP, unknown aluop, unknown alusel, or DIV/DIVU.
- Divider FSM states: IDLE, BYZERO, ON, END.
  - IDLE: if aluop_i is DIV/DIVU and annul_i=0, latch the operands and go to ON, or to BYZERO if reg2_i=0. For DIV, latch absolute values and record both signs. stallreq_o=1 in this cycle.
  - BYZERO: one cycle, stallreq_o=1, result forced to q=0, r=0, then go to END.
  - ON: one restoring shift/subtract step per cycle, counter 0..31. stallreq_o=1. After step 31, go to END.
  - END: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder. Always return to IDLE next cycle.
- Signed fix-up is applied at END: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- Latency, relative to cycle 0 = DIV presented in IDLE:
  - Normal divide: stallreq_o high cycles 0..32 (33 cycles), result and whilo_o in cycle 33.
  - Divide-by-zero: stallreq_o high cycles 0..1, result in cycle 2.
- Operands are latched in IDLE. Changes on reg1_i/reg2_i during ON are ignored.
- annul_i=1 in any state except IDLE: next state IDLE, stallreq_o=0 in that cycle, whilo_o=0, no result.
- END followed by another DIV: IDLE accepts it on the following cycle. There is no back-to-back bypass.
- Outside END, whilo_o=0 and hi_o=lo_o=0.

Test Plan:
- OR reg1=0x0F0F0000, reg2=0x000000FF, wd=5, wreg=1 -> same cycle: wdata_o=0x0F0F00FF, wd_o=5, wreg_o=1, stallreq_o=0.
- SRA reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000. SUBU 0-1 -> 0xFFFFFFFF.
- DIV reg1=0xFFFFFFF9 (-7), reg2=2, held constant -> stallreq_o=1 for exactly 33 cycles. Cycle 33: whilo_o=1, lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). Cycle 34: whilo_o=0.
- DIVU 0xFFFFFFFF/0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF at cycle 33. The same operands under DIV give lo_o=0, hi_o=0xFFFFFFFF.
- DIV by 0 -> stallreq_o high 2 cycles, cycle 2: whilo_o=1, hi_o=lo_o=0.
- DIVU started, annul_i pulsed at cycle 10 -> stallreq_o=0 from cycle 10, no whilo_o pulse. Separately, asserting rst asynchronously at cycle 15 drops all outputs to 0 immediately, and after release an ADDU 3+4 gives 7.
